// File: rtl/simon_pkg.sv
// simon_pkg: Simon 64/128 key-schedule constants and helpers
package simon_pkg;
  localparam int WORD_W = 32;
  localparam int KEY_WORDS = 4;
  localparam logic [5:0] N_ROUNDS = 6'd44;
  localparam logic [61:0] Z3 = 62'h3C2CE51207A635DB;
  localparam logic [31:0] C_CONST = 32'hFFFF_FFFC;
  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
    return (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction
endpackage

// File: rtl/simon_ks_step.sv
// simon_ks_step: one Simon 64/128 key-expansion step; ports k0,k1,k3 window words, z bit in, nk new word out
module simon_ks_step
  import simon_pkg::*;
(
  input  logic [WORD_W-1:0] k0,
  input  logic [WORD_W-1:0] k1,
  input  logic [WORD_W-1:0] k3,
  input  logic              z,
  output logic [WORD_W-1:0] nk
);
  logic [WORD_W-1:0] w_t;
  logic [WORD_W-1:0] w_t2;
  always_comb begin
    w_t  = ror32(k3, 5'd3) ^ k1;
    w_t2 = w_t ^ ror32(w_t, 5'd1);
    nk   = k0 ^ w_t2 ^ C_CONST ^ {{(WORD_W-1){1'b0}}, z};
  end
endmodule

// File: rtl/simon_key_sched.sv
// simon_key_sched: Simon 64/128 on-the-fly round-key generator; ports clk, nrst (sync active-high), key_load/key_in, start, compute in; rk_out, rk_valid, rnd_idx out; zeroize in with SIMON_KS_ZEROIZE_EN
module simon_key_sched
  import simon_pkg::*;
(
  input  logic                        clk,
  input  logic                        nrst,
`ifdef SIMON_KS_ZEROIZE_EN
  input  logic                        zeroize,
`endif
  input  logic                        key_load,
  input  logic [KEY_WORDS*WORD_W-1:0] key_in,
  input  logic                        start,
  input  logic                        compute,
  output logic [WORD_W-1:0]           rk_out,
  output logic                        rk_valid,
  output logic [5:0]                  rnd_idx
);
  logic [KEY_WORDS*WORD_W-1:0] r_master;
  logic [WORD_W-1:0] r_k0, r_k1, r_k2, r_k3;
  logic [5:0] r_rnd;
  logic [WORD_W-1:0] w_nk;
  logic w_adv;
  logic w_z;
  logic w_clr;
  assign w_adv = compute && (r_rnd < N_ROUNDS);
  assign w_z = Z3[r_rnd % 6'd62];
`ifdef SIMON_KS_ZEROIZE_EN
  assign w_clr = nrst || zeroize;
`else
  assign w_clr = nrst;
`endif
  simon_ks_step u_step (
    .k0(r_k0),
    .k1(r_k1),
    .k3(r_k3),
    .z (w_z),
    .nk(w_nk)
  );
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_master <= '0;
      {r_k3, r_k2, r_k1, r_k0} <= '0;
      r_rnd <= '0;
    end else if (key_load) begin
      r_master <= key_in;
      {r_k3, r_k2, r_k1, r_k0} <= key_in;
      r_rnd <= '0;
    end else if (start) begin
      {r_k3, r_k2, r_k1, r_k0} <= r_master;
      r_rnd <= '0;
    end else if (w_adv) begin
      {r_k3, r_k2, r_k1, r_k0} <= {w_nk, r_k3, r_k2, r_k1};
      r_rnd <= r_rnd + 6'd1;
    end
  end
  assign rk_out = r_k0;
  assign rk_valid = w_adv;
  assign rnd_idx = r_rnd;
endmodule

// File: tb/tb_simon_key_sched.sv
// tb_simon_key_sched: directed table plus multi-cycle sequences for simon_key_sched
module tb_simon_key_sched;
  logic clk = 1'b0;
  logic nrst, key_load, start, compute;
  logic [127:0] key_in;
  logic [31:0] rk_out;
  logic rk_valid;
  logic [5:0] rnd_idx;
`ifdef SIMON_KS_ZEROIZE_EN
  logic zeroize;
`endif
  int checks = 0;
  int errors = 0;
  localparam logic [127:0] K1 = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [127:0] K2 = 128'hdeadbeef_cafef00d_01234567_89abcdef;
  logic [31:0] ks [0:47];
  logic [31:0] ex, ey, et;
  typedef struct {
    logic kl, st, cp;
    logic [127:0] key;
    logic ck;
    logic [31:0] rk;
    logic v;
    logic [5:0] idx;
  } vec_t;
  vec_t tbl [0:14];

  simon_key_sched dut (
    .clk(clk),
    .nrst(nrst),
`ifdef SIMON_KS_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .key_load(key_load),
    .key_in(key_in),
    .start(start),
    .compute(compute),
    .rk_out(rk_out),
    .rk_valid(rk_valid),
    .rnd_idx(rnd_idx)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [61:0] z;
    logic [31:0] t;
    z = 62'h3C2CE51207A635DB;
    for (int i = 0; i < 4; i++) ks[i] = key[32*i +: 32];
    for (int i = 4; i < 48; i++) begin
      t = {ks[i-1][2:0], ks[i-1][31:3]} ^ ks[i-3];
      t = t ^ {t[0], t[31:1]};
      ks[i] = ~ks[i-4] ^ t ^ {31'b0, z[i-4]} ^ 32'h3;
    end
  endtask

  task automatic run44(input string tag);
    ex = 32'h656b696c;
    ey = 32'h20646e75;
    for (int i = 0; i < 44; i++) begin
      compute = 1'b1;
      #1;
      chk({tag, "_rk"}, {32'b0, rk_out}, {32'b0, ks[i]});
      chk({tag, "_idx"}, {58'b0, rnd_idx}, i);
      chk({tag, "_valid"}, {63'b0, rk_valid}, 64'd1);
      et = ex;
      ex = ey ^ (({ex[30:0], ex[31]} & {ex[23:0], ex[31:24]}) ^ {ex[29:0], ex[31:30]}) ^ rk_out;
      ey = et;
      tick;
    end
    compute = 1'b0;
    chk({tag, "_ct"}, {ex, ey}, 64'h44c8fc20_b9dfa07a);
  endtask

  initial begin
    nrst = 1'b1; key_load = 1'b0; start = 1'b0; compute = 1'b0; key_in = '0;
`ifdef SIMON_KS_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    tbl[0]  = '{1'b1, 1'b0, 1'b0, K1, 1'b1, 32'h0,        1'b0, 6'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h03020100, 1'b0, 6'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, '0, 1'b1, 32'h03020100, 1'b1, 6'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, '0, 1'b1, 32'h0b0a0908, 1'b1, 6'd1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, '0, 1'b1, 32'h13121110, 1'b1, 6'd2};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, '0, 1'b1, 32'h1b1a1918, 1'b1, 6'd3};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, '0, 1'b1, 32'h70a011c3, 1'b1, 6'd4};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, '0, 1'b0, 32'h0,        1'b1, 6'd5};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h03020100, 1'b0, 6'd0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, K2, 1'b1, 32'h03020100, 1'b1, 6'd0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h89abcdef, 1'b0, 6'd0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, '0, 1'b1, 32'h89abcdef, 1'b1, 6'd0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, '0, 1'b1, 32'h01234567, 1'b1, 6'd1};
    tbl[13] = '{1'b0, 1'b1, 1'b0, '0, 1'b1, 32'hcafef00d, 1'b0, 6'd2};
    tbl[14] = '{1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h89abcdef, 1'b0, 6'd0};
    #1;
    tick; tick;
    nrst = 1'b0;
    #1;
    chk("rst_rk", {32'b0, rk_out}, 64'd0);
    chk("rst_idx", {58'b0, rnd_idx}, 64'd0);
    chk("rst_valid", {63'b0, rk_valid}, 64'd0);
    tick;
    for (int r = 0; r < 15; r++) begin
      key_load = tbl[r].kl; start = tbl[r].st; compute = tbl[r].cp; key_in = tbl[r].key;
      #1;
      if (tbl[r].ck) chk($sformatf("tbl%0d_rk", r), {32'b0, rk_out}, {32'b0, tbl[r].rk});
      chk($sformatf("tbl%0d_valid", r), {63'b0, rk_valid}, {63'b0, tbl[r].v});
      chk($sformatf("tbl%0d_idx", r), {58'b0, rnd_idx}, {58'b0, tbl[r].idx});
      tick;
    end
    key_load = 1'b0; start = 1'b0; compute = 1'b0;
    expand(K1);
    key_in = K1; key_load = 1'b1; tick; key_load = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    run44("s1");
    for (int i = 0; i < 3; i++) begin
      compute = 1'b1;
      #1;
      chk("sat_idx", {58'b0, rnd_idx}, 64'd44);
      chk("sat_valid", {63'b0, rk_valid}, 64'd0);
      chk("sat_rk", {32'b0, rk_out}, {32'b0, ks[44]});
      tick;
    end
    compute = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    run44("s3");
    start = 1'b1; tick; start = 1'b0;
    compute = 1'b1;
    repeat (10) tick;
    key_in = K2; key_load = 1'b1; tick;
    key_load = 1'b0; compute = 1'b0;
    #1;
    chk("kl_mid_idx", {58'b0, rnd_idx}, 64'd0);
    chk("kl_mid_rk", {32'b0, rk_out}, 64'h89abcdef);
    start = 1'b1; tick; start = 1'b0;
    compute = 1'b1;
    repeat (20) tick;
    chk("pre_rst_idx", {58'b0, rnd_idx}, 64'd20);
    nrst = 1'b1; tick; nrst = 1'b0; compute = 1'b0;
    #1;
    chk("mid_rst_rk", {32'b0, rk_out}, 64'd0);
    chk("mid_rst_idx", {58'b0, rnd_idx}, 64'd0);
    chk("mid_rst_valid", {63'b0, rk_valid}, 64'd0);
    start = 1'b1; tick; start = 1'b0;
    chk("lost_master_rk", {32'b0, rk_out}, 64'd0);
`ifdef SIMON_KS_ZEROIZE_EN
    key_in = K1; key_load = 1'b1; tick; key_load = 1'b0;
    compute = 1'b1;
    repeat (5) tick;
    compute = 1'b0;
    zeroize = 1'b1; tick; zeroize = 1'b0;
    chk("zero_idx", {58'b0, rnd_idx}, 64'd0);
    start = 1'b1; tick; start = 1'b0;
    compute = 1'b1;
    #1;
    chk("zero_rk", {32'b0, rk_out}, 64'd0);
    chk("zero_valid", {63'b0, rk_valid}, 64'd1);
    tick;
    compute = 1'b0;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
